// File: rtl/telemetry_uart_tx_if.sv
// rtl/telemetry_uart_tx_if.sv - snapshot inputs and serial/status outputs of the telemetry transmitter
interface telemetry_uart_tx_if;
  logic        send;
  logic [15:0] pitch;
  logic [15:0] roll;
  logic [15:0] yaw;
  logic [15:0] height;
  logic [7:0]  status;
  logic        TxD;
  logic        busy;
  logic        done;
  logic [7:0]  drop_count;

  modport master (
    output send, pitch, roll, yaw, height, status,
    input  TxD, busy, done, drop_count
  );

  modport slave (
    input  send, pitch, roll, yaw, height, status,
    output TxD, busy, done, drop_count
  );
endinterface

// File: rtl/telemetry_uart_tx.sv
// rtl/telemetry_uart_tx.sv - 11-byte checksummed telemetry packet serialiser, 8N1 LSB first
// Optional even-parity bit per byte when TELEM_PARITY_EN is defined.
module telemetry_uart_tx #(
  parameter int          CLK_FREQ = 50000000,
  parameter int          BAUD     = 115200,
  parameter logic [7:0]  HEADER   = 8'hA5
) (
  input  logic clk,
  input  logic rst_n,
  telemetry_uart_tx_if.slave bus
);

  localparam int BIT_DIV = CLK_FREQ / BAUD;
  localparam int CNT_W   = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_DIV - 1);
  localparam logic [3:0]       LAST_BYTE = 4'd10;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef TELEM_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [3:0]       byte_idx;
  logic [7:0]       csum;
  logic [15:0]      snap_pitch;
  logic [15:0]      snap_roll;
  logic [15:0]      snap_yaw;
  logic [15:0]      snap_height;
  logic [7:0]       snap_status;
  logic [7:0]       drop_q;
  logic [7:0]       cur_byte;
  logic             bit_end;
  logic             accept;
  logic             busy_c;
  logic             done_c;
  logic             txd_c;

  assign bit_end = (baud_cnt == BIT_LAST);

  // Byte 10 is the running sum, complete by the time its start bit begins.
  always_comb begin
    cur_byte = csum;
    case (byte_idx)
      4'd0:    cur_byte = HEADER;
      4'd1:    cur_byte = snap_pitch[15:8];
      4'd2:    cur_byte = snap_pitch[7:0];
      4'd3:    cur_byte = snap_roll[15:8];
      4'd4:    cur_byte = snap_roll[7:0];
      4'd5:    cur_byte = snap_yaw[15:8];
      4'd6:    cur_byte = snap_yaw[7:0];
      4'd7:    cur_byte = snap_height[15:8];
      4'd8:    cur_byte = snap_height[7:0];
      4'd9:    cur_byte = snap_status;
      default: cur_byte = csum;
    endcase
  end

  always_comb begin
    state_next = state;
    done_c     = 1'b0;
    txd_c      = 1'b1;
    case (state)
      IDLE: txd_c = 1'b1;
      START: begin
        txd_c = 1'b0;
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        txd_c = cur_byte[bit_idx];
        if (bit_end && bit_idx == 3'd7) begin
`ifdef TELEM_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef TELEM_PARITY_EN
      PARITY: begin
        txd_c = ^cur_byte;
        if (bit_end) state_next = STOP;
      end
`endif
      STOP: begin
        txd_c = 1'b1;
        if (bit_end) begin
          if (byte_idx != LAST_BYTE) begin
            state_next = START;
          end else begin
            done_c     = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // The final stop-bit cycle already counts as free so packets can run back to back.
    busy_c = (state != IDLE) && !done_c;
    accept = bus.send && !busy_c;
    if (accept) state_next = START;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      baud_cnt    <= '0;
      bit_idx     <= '0;
      byte_idx    <= '0;
      csum        <= '0;
      snap_pitch  <= '0;
      snap_roll   <= '0;
      snap_yaw    <= '0;
      snap_height <= '0;
      snap_status <= '0;
      drop_q      <= '0;
    end else begin
      if (bus.send && busy_c && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      if (accept) begin
        snap_pitch  <= bus.pitch;
        snap_roll   <= bus.roll;
        snap_yaw    <= bus.yaw;
        snap_height <= bus.height;
        snap_status <= bus.status;
        baud_cnt    <= '0;
        bit_idx     <= '0;
        byte_idx    <= '0;
        csum        <= '0;
      end else if (state != IDLE) begin
        if (bit_end) begin
          baud_cnt <= '0;
          if (state == DATA) bit_idx <= bit_idx + 3'd1;
          if (state == STOP && byte_idx != LAST_BYTE) begin
            byte_idx <= byte_idx + 4'd1;
            csum     <= csum + cur_byte;
          end
        end else begin
          baud_cnt <= baud_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.TxD        = txd_c;
  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_telemetry_uart_tx.sv
// tb/tb_telemetry_uart_tx.sv - directed bench for telemetry_uart_tx with packet-level reference model
module tb_telemetry_uart_tx;

  localparam int BIT_DIV = 434;
`ifdef TELEM_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif
  localparam int PKT_LEN = 11 * FRAME * BIT_DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  telemetry_uart_tx_if bus ();

  telemetry_uart_tx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int nvec  = 0;
  int nfail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected line level derived from cycle offset into the packet.
  logic [7:0] m_bytes [11];
  bit         m_active = 1'b0;
  int         m_off    = 0;
  int         m_drop   = 0;
  logic       e_txd, e_busy, e_done;
  int         bn, by, pos;
  logic [7:0] d, sum;

  always @(negedge clk) begin
    if (rst_n) begin
      m_active = 1'b0;
      m_off    = 0;
      m_drop   = 0;
      e_txd = 1'b1; e_busy = 1'b0; e_done = 1'b0;
    end else if (m_active) begin
      bn  = m_off / BIT_DIV;
      by  = bn / FRAME;
      pos = bn % FRAME;
      d   = m_bytes[by];
      if (pos == 0)                      e_txd = 1'b0;
      else if (pos <= 8)                 e_txd = d[pos-1];
      else if (pos == 9 && FRAME == 11)  e_txd = ^d;
      else                               e_txd = 1'b1;
      e_done = (m_off == PKT_LEN - 1);
      e_busy = !e_done;
    end else begin
      e_txd = 1'b1; e_busy = 1'b0; e_done = 1'b0;
    end
    check("cycle {txd,busy,done,drop}", {21'd0, bus.TxD, bus.busy, bus.done, bus.drop_count},
          {21'd0, e_txd, e_busy, e_done, m_drop[7:0]});
    if (!rst_n) begin
      if (bus.send && e_busy && m_drop < 255) m_drop++;
      if (bus.send && !e_busy) begin
        m_bytes[0] = 8'hA5;
        m_bytes[1] = bus.pitch[15:8];  m_bytes[2] = bus.pitch[7:0];
        m_bytes[3] = bus.roll[15:8];   m_bytes[4] = bus.roll[7:0];
        m_bytes[5] = bus.yaw[15:8];    m_bytes[6] = bus.yaw[7:0];
        m_bytes[7] = bus.height[15:8]; m_bytes[8] = bus.height[7:0];
        m_bytes[9] = bus.status;
        sum = 8'd0;
        for (int i = 0; i < 10; i++) sum = sum + m_bytes[i];
        m_bytes[10] = sum;
        m_active = 1'b1;
        m_off    = 0;
      end else if (m_active) begin
        if (e_done) m_active = 1'b0;
        else        m_off++;
      end
    end
  end

  // Line receiver: samples mid-bit and collects bytes (and parity bits).
  logic [7:0] rx_q [$];
  bit         rx_par [$];
  logic [7:0] rx_b;

  always begin
    @(negedge clk);
    if (bus.TxD === 1'b0) begin
      repeat (BIT_DIV / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BIT_DIV) @(negedge clk);
        rx_b[i] = bus.TxD;
      end
`ifdef TELEM_PARITY_EN
      repeat (BIT_DIV) @(negedge clk);
      rx_par.push_back(bus.TxD);
`endif
      repeat (BIT_DIV) @(negedge clk);
      rx_q.push_back(rx_b);
    end
  end

  logic [7:0] exp_pkt [11];
  int         n, lowrun;
  bit         seen;

  task automatic apply_vec();
    bus.pitch  = 16'h1234;
    bus.roll   = 16'hFFFE;
    bus.yaw    = 16'h0001;
    bus.height = 16'h03E8;
    bus.status = 8'h03;
  endtask

  initial begin
    exp_pkt = '{8'hA5, 8'h12, 8'h34, 8'hFF, 8'hFE, 8'h00, 8'h01, 8'h03, 8'hE8, 8'h03, 8'hD7};
    bus.send = 1'b0;
    bus.pitch = '0; bus.roll = '0; bus.yaw = '0; bus.height = '0; bus.status = '0;

    repeat (4) @(posedge clk);
    #1;
    check("reset_txd",  bus.TxD, 1);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_drop", bus.drop_count, 0);
    rst_n = 1'b0;
    repeat (1000) @(posedge clk);

    // Packet A, abandoned by reset in the middle of byte 4
    #1 apply_vec(); bus.send = 1'b1;
    @(posedge clk); #1 bus.send = 1'b0;
    repeat (4 * FRAME * BIT_DIV + 2000) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst_mid_txd",  bus.TxD, 1);
    check("rst_mid_busy", bus.busy, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3000) @(posedge clk);
    rx_q.delete();
    rx_par.delete();

    // Packet B: inputs zeroed after accept, drops, back-to-back send in done cycle
    #1 apply_vec(); bus.send = 1'b1;
    @(posedge clk);
    #1 bus.send = 1'b0;
    bus.pitch = '0; bus.roll = '0; bus.yaw = '0; bus.height = '0; bus.status = '0;
    n = 0; lowrun = 0; seen = 1'b0;
    while (n < PKT_LEN + 2000) begin
      @(negedge clk);
      n++;
      if (bus.TxD === 1'b0 && lowrun == n - 1) lowrun++;
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      bus.send = (n == 1000 || n == 1500 || n == 2000 || (n >= 3000 && n < 3300) || n == PKT_LEN - 1);
      if (n == PKT_LEN - 1) bus.pitch = 16'h5A0F;
    end
    check("done_seen",   seen, 1);
    check("done_cycle",  n, PKT_LEN);
    check("start_width", lowrun, BIT_DIV);
    check("rx_count",    rx_q.size(), 11);
    for (int i = 0; i < 11; i++)
      check($sformatf("rx_byte%0d", i), (i < rx_q.size()) ? rx_q[i] : 32'hDEAD, exp_pkt[i]);
`ifdef TELEM_PARITY_EN
    check("parity_03", (rx_par.size() > 9) ? rx_par[9] : 32'hDEAD, 0);
    check("parity_01", (rx_par.size() > 6) ? rx_par[6] : 32'hDEAD, 1);
`endif
    @(posedge clk); #1 bus.send = 1'b0;
    rx_q.delete();
    rx_par.delete();
    @(negedge clk);
    check("b2b_start_txd", bus.TxD, 0);
    check("b2b_busy",      bus.busy, 1);
    check("drop_sat",      bus.drop_count, 255);

    // Packet C: first two bytes reflect the pitch presented in the done cycle
    repeat (2 * FRAME * BIT_DIV + 300) @(negedge clk);
    check("c_rx_count", (rx_q.size() >= 2) ? 1 : 0, 1);
    check("c_byte0", (rx_q.size() > 0) ? rx_q[0] : 32'hDEAD, 8'hA5);
    check("c_byte1", (rx_q.size() > 1) ? rx_q[1] : 32'hDEAD, 8'h5A);

    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
